// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: digit-serial adder sequencer.
// Accepts one WIDTH-bit add per in_valid/in_ready handshake and evaluates it
// over NDIG = WIDTH/DIGIT cycles using a single DIGIT-bit ripple slice, with
// the inter-digit carry held in a register. The result is offered on
// out_valid/out_ready and held until the sink takes it.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (a, b, cin sampled at the accept edge)
//   a, b, cin         operands and carry-in to bit 0
//   out_valid/out_ready result handshake
//   sum, cout, ovf    (a+b+cin) mod 2^WIDTH, carry out of MSB, signed overflow
//   busy              high while an operation is in RUN or DONE
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    // Parameter sanity: the operand must split into whole digits.
    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_adder_ctrl: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [DIGIT-1:0]  slice_sum;
    logic              slice_cout;
    logic              slice_cmsb;

    // DIGIT-bit ripple slice over the low digit of both operand registers.
    // slice_cmsb is the carry into the slice's top cell; on the final digit
    // that is the carry into bit WIDTH-1, needed for signed overflow.
    always_comb begin : p_slice
        logic c;
        c          = carry_q;
        slice_sum  = '0;
        slice_cmsb = 1'b0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            if (i == int'(DIGIT) - 1) begin
                slice_cmsb = c;
            end
            slice_sum[i] = opa_q[i] ^ opb_q[i] ^ c;
            c = (opa_q[i] & opb_q[i]) | (c & (opa_q[i] ^ opb_q[i]));
        end
        slice_cout = c;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        count_d = count_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = cin;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // New digit enters at the MS end; after NDIG shifts the
                // first digit has reached bit 0.
                sum_d   = WIDTH'({slice_sum, sum_q} >> DIGIT);
                opa_d   = opa_q >> DIGIT;
                opb_d   = opb_q >> DIGIT;
                carry_d = slice_cout;
                if (count_q == CW'(NDIG - 1)) begin
                    cout_d  = slice_cout;
                    ovf_d   = slice_cmsb ^ slice_cout;
                    state_d = S_DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // in_ready is gated by rst so no operand is taken while reset is held.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
